// File: rtl/pll_retune_ctrl_pkg.sv
`default_nettype none
// ============================================================
// pll_pkg : shared states, widths and default gains for pll_retune_ctrl
// Revision: 1.0
// ============================================================
package pll_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      APPLY   = 3'd1,
      ACQUIRE = 3'd2,
      SETTLE  = 3'd3,
      TRACK   = 3'd4
   } state_t;

   localparam int GAIN_W = 5;
   localparam int CFG_W  = 32;

   localparam logic [GAIN_W-1:0] DEF_KP_ACQ = 5'd17;
   localparam logic [GAIN_W-1:0] DEF_KI_ACQ = 5'd13;
   localparam logic [GAIN_W-1:0] DEF_KP_TRK = 5'd13;
   localparam logic [GAIN_W-1:0] DEF_KI_TRK = 5'd9;

endpackage
`default_nettype wire

// File: rtl/pll_retune_ctrl_if.sv
`default_nettype none
// ============================================================
// pll_retune_ctrl_if : retune request/response handshake bundle
// Revision: 1.0
// ============================================================
interface pll_retune_ctrl_if;
   import pll_pkg::*;

   logic             req_valid;
   logic             req_ready;
   logic [CFG_W-1:0] req_div_val;
   logic [CFG_W-1:0] req_init_freq;
   logic             resp_valid;
   logic             resp_ok;

   modport master (
      output req_valid, req_div_val, req_init_freq,
      input  req_ready, resp_valid, resp_ok
   );

   modport slave (
      input  req_valid, req_div_val, req_init_freq,
      output req_ready, resp_valid, resp_ok
   );
endinterface
`default_nettype wire

// File: rtl/pll_retune_ctrl_lock_filter.sv
`default_nettype none
// ============================================================
// pll_lock_filter : saturating consecutive-cycle counter with clear and match
// Revision: 1.0
// ============================================================
module pll_lock_filter #(
   parameter int CNT_W = 16,
   parameter int MATCH = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic match
);
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign match = (cnt == CNT_W'(MATCH - 1));
endmodule
`default_nettype wire

// File: rtl/pll_retune_ctrl.sv
`default_nettype none
// ============================================================
// pll_retune_ctrl : DPLL retune sequencer, gain scheduler and lock supervisor
// Optional statistics outputs under PLL_RETUNE_STATS_EN.  Revision: 1.0
// ============================================================
module pll_retune_ctrl
   import pll_pkg::*;
#(
   parameter logic [CFG_W-1:0]  RST_DIV     = 32'd8,
   parameter logic [CFG_W-1:0]  RST_FREQ    = 32'h0100_0000,
   parameter logic [GAIN_W-1:0] KP_ACQ      = DEF_KP_ACQ,
   parameter logic [GAIN_W-1:0] KI_ACQ      = DEF_KI_ACQ,
   parameter logic [GAIN_W-1:0] KP_TRK      = DEF_KP_TRK,
   parameter logic [GAIN_W-1:0] KI_TRK      = DEF_KI_TRK,
   parameter int                RST_CYCLES  = 4,
   parameter int                LOCK_HOLD   = 64,
   parameter int                UNLOCK_FILT = 32,
   parameter int                TIMEOUT_CYC = 4096
) (
   input  logic                sys_clk,
   input  logic                rst_n,
   pll_retune_ctrl_if.slave    req,
   input  logic                lock_in,
   output logic                pll_rst_n,
   output logic [CFG_W-1:0]    div_val,
   output logic [CFG_W-1:0]    initial_freq,
   output logic [GAIN_W-1:0]   kp_shift,
   output logic [GAIN_W-1:0]   ki_shift,
   output logic                busy,
   output logic                locked
`ifdef PLL_RETUNE_STATS_EN
   ,
   output logic [15:0]         relock_cnt,
   output logic [15:0]         timeout_cnt
`endif
);
   state_t      state, nxt;
   logic [7:0]  rst_cnt;
   logic [15:0] tmo_cnt;
   logic        pend;
   logic        accept, timeout, lock_done, reacq;
   logic        hold_match, unlock_match;
   logic        in_acq;

   assign accept = req.req_valid && req.req_ready;
   assign in_acq = (state == ACQUIRE) || (state == SETTLE);

   pll_lock_filter #(.CNT_W(16), .MATCH(LOCK_HOLD)) u_hold (
      .clk   (sys_clk),
      .rst_n (rst_n),
      .clr   ((state != SETTLE) || !lock_in),
      .inc   (state == SETTLE),
      .match (hold_match)
   );

   pll_lock_filter #(.CNT_W(8), .MATCH(UNLOCK_FILT)) u_unlock (
      .clk   (sys_clk),
      .rst_n (rst_n),
      .clr   ((state != TRACK) || lock_in),
      .inc   ((state == TRACK) && !lock_in),
      .match (unlock_match)
   );

   // Timeout wins over lock events; a request in TRACK wins over re-acquire.
   always_comb begin
      nxt       = state;
      timeout   = 1'b0;
      lock_done = 1'b0;
      reacq     = 1'b0;
      case (state)
         IDLE:    if (accept) nxt = APPLY;
         APPLY:   if (rst_cnt == 8'(RST_CYCLES - 1)) nxt = ACQUIRE;
         ACQUIRE: begin
            if (tmo_cnt == 16'(TIMEOUT_CYC - 1)) begin
               timeout = 1'b1;
               nxt     = IDLE;
            end else if (lock_in) begin
               nxt = SETTLE;
            end
         end
         SETTLE: begin
            if (tmo_cnt == 16'(TIMEOUT_CYC - 1)) begin
               timeout = 1'b1;
               nxt     = IDLE;
            end else if (!lock_in) begin
               nxt = ACQUIRE;
            end else if (hold_match) begin
               lock_done = 1'b1;
               nxt       = TRACK;
            end
         end
         TRACK: begin
            if (accept) begin
               nxt = APPLY;
            end else if (unlock_match && !lock_in) begin
               reacq = 1'b1;
               nxt   = ACQUIRE;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         pll_rst_n      <= 1'b0;
         div_val        <= RST_DIV;
         initial_freq   <= RST_FREQ;
         kp_shift       <= KP_ACQ;
         ki_shift       <= KI_ACQ;
         busy           <= 1'b0;
         locked         <= 1'b0;
         req.req_ready  <= 1'b1;
         req.resp_valid <= 1'b0;
         req.resp_ok    <= 1'b0;
         rst_cnt        <= '0;
         tmo_cnt        <= '0;
         pend           <= 1'b0;
      end else begin
         state          <= nxt;
         pll_rst_n      <= (nxt == ACQUIRE) || (nxt == SETTLE) || (nxt == TRACK);
         busy           <= (nxt == APPLY) || (nxt == ACQUIRE) || (nxt == SETTLE);
         locked         <= (nxt == TRACK);
         req.req_ready  <= (nxt == IDLE) || (nxt == TRACK);
         kp_shift       <= ((nxt == SETTLE) || (nxt == TRACK)) ? KP_TRK : KP_ACQ;
         ki_shift       <= ((nxt == SETTLE) || (nxt == TRACK)) ? KI_TRK : KI_ACQ;
         req.resp_valid <= (lock_done || timeout) && pend;
         req.resp_ok    <= lock_done && pend;
         rst_cnt        <= ((state == APPLY) && (nxt == APPLY)) ? rst_cnt + 8'd1 : 8'd0;
         if (in_acq && !timeout) begin
            if (tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;
         end else begin
            tmo_cnt <= '0;
         end
         if (accept) begin
            div_val      <= req.req_div_val;
            initial_freq <= req.req_init_freq;
            pend         <= 1'b1;
         end else if (lock_done || timeout) begin
            pend <= 1'b0;
         end
      end
   end

`ifdef PLL_RETUNE_STATS_EN
   always_ff @(posedge sys_clk) begin
      if (!rst_n || accept) begin
         relock_cnt  <= '0;
         timeout_cnt <= '0;
      end else begin
         if (reacq && (relock_cnt != 16'hFFFF)) relock_cnt <= relock_cnt + 16'd1;
         if (timeout && (timeout_cnt != 16'hFFFF)) timeout_cnt <= timeout_cnt + 16'd1;
      end
   end
`endif

endmodule
`default_nettype wire
